nibbler_ctrl: RTL

- Instruction sequencer for the 4-bit Nibbler datapath.
- Fetches 8-bit instructions from a synchronous ROM and drives the ALU's opcode and operand inputs.
- Consumes the ALU's result, carry and zero; holds the accumulator and flag registers.
- Resolves conditional jumps and runs valid/ready handshakes on the 4-bit output and input ports.

---
 rtl/nibbler_pkg.sv | 64 ++++++
 rtl/nibbler_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/nibbler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nibbler_pkg
// Desc     : Shared constants for the Nibbler sequencer: ALU opcodes, ISA
//            opcodes, controller state encoding and small decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package nibbler_pkg;

  // ALU opcodes driven on alu_op (shared with the ALU)
  localparam logic [2:0] ALU_OUT = 3'b000;
  localparam logic [2:0] ALU_CMP = 3'b001;
  localparam logic [2:0] ALU_LD  = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;

  // ISA opcodes held in ir[7:4]
  localparam logic [3:0] OP_OUT  = 4'h0;
  localparam logic [3:0] OP_CMP  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_NOR  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JC   = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JNZ  = 4'hB;
  localparam logic [3:0] OP_IN   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_DECODE   = 3'd1,
    ST_FETCH2   = 3'd2,
    ST_JUMP     = 3'd3,
    ST_EXEC     = 3'd4,
    ST_OUT_WAIT = 3'd5,
    ST_IN_WAIT  = 3'd6,
    ST_HALT     = 3'd7
  } state_e;

  // ALU opcode presented during EXEC; non-ALU instructions leave it at OUT
  function automatic logic [2:0] alu_op_of(input logic [3:0] op);
    case (op)
      OP_CMP:  return ALU_CMP;
      OP_LD:   return ALU_LD;
      OP_ADD:  return ALU_ADD;
      OP_NOR:  return ALU_NOR;
      default: return ALU_OUT;
    endcase
  endfunction

  // Two-byte instructions (all four share the 10xx opcode pattern)
  function automatic logic is_jump(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_JC) || (op == OP_JZ) || (op == OP_JNZ);
  endfunction

  // Single-byte instructions that need an EXEC cycle; everything else is a NOP
  function automatic logic is_exec(input logic [3:0] op);
    return (op == OP_OUT) || (op == OP_CMP) || (op == OP_LD) || (op == OP_ADD) ||
           (op == OP_NOR) || (op == OP_IN)  || (op == OP_HALT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibbler_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibbler_ctrl
// Desc     : Instruction sequencer for the 4-bit Nibbler datapath. Fetches
//            from a synchronous ROM, drives the external ALU, holds the
//            accumulator and flags, resolves jumps and runs the I/O ports.
// Revision : 1.0 - initial release
// ============================================================================
module nibbler_ctrl
  import nibbler_pkg::*;
#(
  parameter int PC_W    = 12,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [2:0]         alu_op,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  input  logic [3:0]         alu_out,
  input  logic               alu_carry,
  input  logic               alu_zero,
  output logic [3:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic [3:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [3:0]         acc,
  output logic               carry_flag,
  output logic               zero_flag,
  output logic               halted
);

  state_e             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic [3:0]         acc_q;
  logic               carry_q;
  logic               zero_q;
  logic [2:0]         alu_op_q;
  logic [3:0]         out_data_q;
  logic               out_valid_q;
  logic               in_ready_q;
  logic               halted_q;

  logic [PC_W-1:0]    pc_d;
  logic [3:0]         rom_op;
  logic [3:0]         ir_op;
  logic [INSTR_W+3:0] jump_target;
  logic               jump_taken;

  assign pc_d        = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  assign rom_op      = rom_data[7:4];
  assign ir_op       = ir_q[7:4];
  // Second jump byte arrives on rom_data during JUMP
  assign jump_target = {ir_q[3:0], rom_data};

  // Jump condition uses only the latched flags
  always_comb begin
    jump_taken = 1'b0;
    case (ir_op)
      OP_JMP:  jump_taken = 1'b1;
      OP_JC:   jump_taken = carry_q;
      OP_JZ:   jump_taken = zero_q;
      OP_JNZ:  jump_taken = ~zero_q;
      default: jump_taken = 1'b0;
    endcase
  end

  // Sequencer FSM with the accumulator, flags and port registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      acc_q       <= 4'h0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      alu_op_q    <= ALU_OUT;
      out_data_q  <= 4'h0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          pc_q    <= pc_d;
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          ir_q     <= rom_data;
          alu_op_q <= ALU_OUT;
          if (is_jump(rom_op)) begin
            state_q <= ST_FETCH2;
          end else if (is_exec(rom_op)) begin
            // Registered so alu_op is valid for the whole EXEC cycle
            alu_op_q <= alu_op_of(rom_op);
            state_q  <= ST_EXEC;
          end else begin
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH2: begin
          pc_q    <= pc_d;
          state_q <= ST_JUMP;
        end
        ST_JUMP: begin
          if (jump_taken) begin
            pc_q <= PC_W'(jump_target);
          end
          state_q <= ST_FETCH;
        end
        ST_EXEC: begin
          alu_op_q <= ALU_OUT;
          state_q  <= ST_FETCH;
          case (ir_op)
            OP_OUT: begin
              out_data_q  <= acc_q;
              out_valid_q <= 1'b1;
              state_q     <= ST_OUT_WAIT;
            end
            OP_CMP: begin
              carry_q <= alu_carry;
              zero_q  <= alu_zero;
            end
            OP_LD: begin
              acc_q <= ir_q[3:0];
            end
            OP_ADD: begin
              acc_q   <= alu_out;
              carry_q <= alu_carry;
              zero_q  <= alu_zero;
            end
            OP_NOR: begin
              acc_q <= alu_out;
            end
            OP_IN: begin
              in_ready_q <= 1'b1;
              state_q    <= ST_IN_WAIT;
            end
            OP_HALT: begin
              halted_q <= 1'b1;
              state_q  <= ST_HALT;
            end
            default: begin
            end
          endcase
        end
        ST_OUT_WAIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_FETCH;
          end
        end
        ST_IN_WAIT: begin
          if (in_valid) begin
            acc_q      <= in_data;
            in_ready_q <= 1'b0;
            state_q    <= ST_FETCH;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  // pc only moves in FETCH/FETCH2/JUMP, so the address holds while halted
  assign rom_addr   = pc_q;
  assign alu_op     = alu_op_q;
  assign alu_a      = acc_q;
  assign alu_b      = ir_q[3:0];
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign in_ready   = in_ready_q;
  assign acc        = acc_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign halted     = halted_q;

endmodule
`default_nettype wire
